// File: rtl/tmr_pkg.sv
// Shared encodings for the TMR fault monitor: FSM states, voter bit positions
// and a helper that classifies a 3-bit disagreement code.
package tmr_pkg;

  typedef enum logic [1:0] {
    S_OK       = 2'd0,
    S_DEGRADED = 2'd1,
    S_FATAL    = 2'd2
  } state_t;

  localparam int VS_A = 0;
  localparam int VS_B = 1;
  localparam int VS_C = 2;

  localparam logic [2:0] VS_AGREE = 3'b000;

  // True when two or more of the three bits are set.
  function automatic logic is_multi(input logic [2:0] vs);
    return (vs[0] & vs[1]) | (vs[0] & vs[2]) | (vs[1] & vs[2]);
  endfunction

endpackage

// File: rtl/fault_leaky_counter.sv
// Saturating up/down fault counter. Increment beats decrement and the count
// never goes below zero.
module fault_leaky_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (!rst_in || clr) begin
      cnt <= '0;
    end else if (inc) begin
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/tmr_fault_monitor.sv
// Watches the TMR voter's disagreement code, keeps leaky per-core fault counts,
// flags persistently bad cores and latches a sticky fatal state.
module tmr_fault_monitor
  import tmr_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int DEGRADE_THRESH = 4,
  parameter int WINDOW         = 256
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic [2:0]       Voter_state,
  input  logic [31:0]      PC_Top,
  input  logic             core_hold,
  input  logic             clr,
  output logic [CNT_W-1:0] fault_cnt_A,
  output logic [CNT_W-1:0] fault_cnt_B,
  output logic [CNT_W-1:0] fault_cnt_C,
  output logic [2:0]       core_degraded,
  output logic             fatal,
  output logic [31:0]      last_fault_pc,
  output logic [2:0]       last_fault_state,
  output logic             fault_irq,
  output state_t           dbg_state
);

  localparam int              WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  logic [WIN_W-1:0] win_cnt;
  logic             wrap;
  logic [2:0]       prev_vs;
  logic             evt;
  logic             evt_corr;
  logic             evt_unc;
  logic [2:0]       inc;
  logic [2:0]       over_thresh;
  state_t           state_q;
  state_t           state_d;

  // Window counter keeps running while the cores are held.
  always_ff @(posedge clk) begin
    if (!rst_in || clr) begin
      win_cnt <= '0;
    end else if (win_cnt == WIN_LAST) begin
      win_cnt <= '0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
    end
  end

  assign wrap = (win_cnt == WIN_LAST);

  // A held cycle is invisible: it neither raises events nor updates prev_vs.
  always_ff @(posedge clk) begin
    if (!rst_in || clr) begin
      prev_vs <= VS_AGREE;
    end else if (!core_hold) begin
      prev_vs <= Voter_state;
    end
  end

  assign evt      = !core_hold && (Voter_state != VS_AGREE) && (Voter_state != prev_vs);
  assign evt_unc  = evt && is_multi(Voter_state);
  assign evt_corr = evt && !is_multi(Voter_state);
  assign inc      = {3{evt_corr}} & Voter_state;

  fault_leaky_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk(clk), .rst_in(rst_in), .clr(clr), .inc(inc[VS_A]), .dec(wrap), .cnt(fault_cnt_A)
  );
  fault_leaky_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk(clk), .rst_in(rst_in), .clr(clr), .inc(inc[VS_B]), .dec(wrap), .cnt(fault_cnt_B)
  );
  fault_leaky_counter #(.CNT_W(CNT_W)) u_cnt_c (
    .clk(clk), .rst_in(rst_in), .clr(clr), .inc(inc[VS_C]), .dec(wrap), .cnt(fault_cnt_C)
  );

  assign over_thresh[VS_A] = 32'(fault_cnt_A) >= 32'(DEGRADE_THRESH);
  assign over_thresh[VS_B] = 32'(fault_cnt_B) >= 32'(DEGRADE_THRESH);
  assign over_thresh[VS_C] = 32'(fault_cnt_C) >= 32'(DEGRADE_THRESH);

  // Degraded flags are sticky; leak below the threshold does not clear them.
  always_ff @(posedge clk) begin
    if (!rst_in || clr) begin
      core_degraded <= '0;
    end else begin
      core_degraded <= core_degraded | over_thresh;
    end
  end

  // Capture is overwrite-on-event; clr suppresses the event entirely.
  always_ff @(posedge clk) begin
    if (!rst_in || clr) begin
      fault_irq        <= 1'b0;
      last_fault_pc    <= '0;
      last_fault_state <= VS_AGREE;
    end else begin
      fault_irq <= evt;
      if (evt) begin
        last_fault_pc    <= PC_Top;
        last_fault_state <= Voter_state;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_in || clr) begin
      state_q <= S_OK;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OK, S_DEGRADED: begin
        if (evt_unc || is_multi(core_degraded)) begin
          state_d = S_FATAL;
        end else if (core_degraded != 3'b000) begin
          state_d = S_DEGRADED;
        end
      end
      S_FATAL: state_d = S_FATAL;
      default: state_d = S_OK;
    endcase
  end

  always_comb begin
    fatal     = (state_q == S_FATAL);
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Directed bench for tmr_fault_monitor; a second instance with 2-bit counters
// covers saturation.
module tb_tmr_fault_monitor;
  import tmr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [2:0]  Voter_state;
  logic [31:0] PC_Top;
  logic        core_hold;
  logic        clr;

  logic [7:0]  fault_cnt_A, fault_cnt_B, fault_cnt_C;
  logic [2:0]  core_degraded;
  logic        fatal;
  logic [31:0] last_fault_pc;
  logic [2:0]  last_fault_state;
  logic        fault_irq;
  state_t      dbg_state;

  logic [1:0]  s_cnt_A, s_cnt_B, s_cnt_C;
  logic [2:0]  s_core_degraded;
  logic        s_fatal;
  logic [31:0] s_last_fault_pc;
  logic [2:0]  s_last_fault_state;
  logic        s_fault_irq;
  state_t      s_dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tmr_fault_monitor #(.CNT_W(8), .DEGRADE_THRESH(4), .WINDOW(256)) u_dut (
    .clk(clk), .rst_in(rst_in), .Voter_state(Voter_state), .PC_Top(PC_Top),
    .core_hold(core_hold), .clr(clr),
    .fault_cnt_A(fault_cnt_A), .fault_cnt_B(fault_cnt_B), .fault_cnt_C(fault_cnt_C),
    .core_degraded(core_degraded), .fatal(fatal), .last_fault_pc(last_fault_pc),
    .last_fault_state(last_fault_state), .fault_irq(fault_irq), .dbg_state(dbg_state)
  );

  tmr_fault_monitor #(.CNT_W(2), .DEGRADE_THRESH(4), .WINDOW(256)) u_sat (
    .clk(clk), .rst_in(rst_in), .Voter_state(Voter_state), .PC_Top(PC_Top),
    .core_hold(core_hold), .clr(clr),
    .fault_cnt_A(s_cnt_A), .fault_cnt_B(s_cnt_B), .fault_cnt_C(s_cnt_C),
    .core_degraded(s_core_degraded), .fatal(s_fatal), .last_fault_pc(s_last_fault_pc),
    .last_fault_state(s_last_fault_state), .fault_irq(s_fault_irq), .dbg_state(s_dbg_state)
  );

  // Inputs change on the falling edge; each step crosses one rising edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [2:0] vs, input logic [31:0] pc);
    Voter_state = vs;
    PC_Top      = pc;
    step(1);
    Voter_state = 3'b000;
    step(1);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; clr = 1'b0; core_hold = 1'b0;
    Voter_state = 3'b001; PC_Top = 32'h0000_0100;
    step(2);
    checks++; if ({fault_cnt_A, fault_cnt_B, fault_cnt_C} !== 24'd0) begin
      errors++; $display("FAIL reset_cnts got %h exp 0", {fault_cnt_A, fault_cnt_B, fault_cnt_C}); end
    checks++; if ({core_degraded, fatal, fault_irq} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 0", {core_degraded, fatal, fault_irq}); end
    checks++; if ({last_fault_pc, last_fault_state} !== 35'd0) begin
      errors++; $display("FAIL reset_capture got %h exp 0", {last_fault_pc, last_fault_state}); end
    checks++; if (dbg_state !== S_OK) begin
      errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, S_OK); end
    rst_in = 1'b1;
    step(1);
    checks++; if (fault_cnt_A !== 8'd1) begin
      errors++; $display("FAIL first_evt_cnt_a got %0d exp 1", fault_cnt_A); end
    checks++; if (fault_irq !== 1'b1) begin
      errors++; $display("FAIL first_evt_irq got %b exp 1", fault_irq); end
    checks++; if (last_fault_state !== 3'b001 || last_fault_pc !== 32'h100) begin
      errors++; $display("FAIL first_evt_capture got %b/%h exp 001/100", last_fault_state, last_fault_pc); end
    Voter_state = 3'b000;
    step(1);
    checks++; if (fault_irq !== 1'b0) begin
      errors++; $display("FAIL irq_one_cycle got %b exp 0", fault_irq); end
    Voter_state = 3'b010; rst_in = 1'b0;
    step(1);
    checks++; if (fault_irq !== 1'b0 || fault_cnt_A !== 8'd0 || fault_cnt_B !== 8'd0) begin
      errors++; $display("FAIL reset_mid_event got irq=%b a=%0d b=%0d exp 0/0/0", fault_irq, fault_cnt_A, fault_cnt_B); end
    rst_in = 1'b1; Voter_state = 3'b000;
    step(1);
  endtask

  task automatic test_persistent();
    int irqs;
    do_clr();
    irqs = 0;
    Voter_state = 3'b010; PC_Top = 32'h0000_0200;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (fault_irq) irqs++;
    end
    checks++; if (fault_cnt_B !== 8'd1 || irqs != 1) begin
      errors++; $display("FAIL persistent_once got cnt=%0d irqs=%0d exp 1/1", fault_cnt_B, irqs); end
    Voter_state = 3'b000; step(1);
    Voter_state = 3'b010; step(1);
    checks++; if (fault_cnt_B !== 8'd2 || fault_irq !== 1'b1) begin
      errors++; $display("FAIL rearm got cnt=%0d irq=%b exp 2/1", fault_cnt_B, fault_irq); end
    Voter_state = 3'b000; step(1);
    irqs = 0;
    core_hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      Voter_state = (i % 2 == 1) ? 3'b010 : 3'b000;
      step(1);
      if (fault_irq) irqs++;
    end
    checks++; if (fault_cnt_B !== 8'd2 || irqs != 0) begin
      errors++; $display("FAIL hold_suppress got cnt=%0d irqs=%0d exp 2/0", fault_cnt_B, irqs); end
    core_hold = 1'b0; Voter_state = 3'b000;
    step(1);
  endtask

  task automatic test_degrade_decay();
    do_clr();
    for (int i = 0; i < 4; i++) pulse(3'b100, 32'h300 + 32'(i));
    step(2);
    checks++; if (fault_cnt_C !== 8'd4 || core_degraded !== 3'b100) begin
      errors++; $display("FAIL degrade_c got cnt=%0d deg=%b exp 4/100", fault_cnt_C, core_degraded); end
    checks++; if (dbg_state !== S_DEGRADED || fatal !== 1'b0) begin
      errors++; $display("FAIL degrade_state got %0d fatal=%b exp %0d/0", dbg_state, fatal, S_DEGRADED); end
    step(512);
    checks++; if (fault_cnt_C !== 8'd2 || core_degraded !== 3'b100) begin
      errors++; $display("FAIL decay got cnt=%0d deg=%b exp 2/100", fault_cnt_C, core_degraded); end
    checks++; if (dbg_state !== S_DEGRADED) begin
      errors++; $display("FAIL decay_state got %0d exp %0d", dbg_state, S_DEGRADED); end
  endtask

  task automatic test_fatal();
    do_clr();
    pulse(3'b001, 32'h10);
    Voter_state = 3'b111; PC_Top = 32'h0000_0040;
    step(1);
    checks++; if (fatal !== 1'b1 || fault_irq !== 1'b1) begin
      errors++; $display("FAIL fatal_set got fatal=%b irq=%b exp 1/1", fatal, fault_irq); end
    checks++; if (last_fault_pc !== 32'h40 || last_fault_state !== 3'b111) begin
      errors++; $display("FAIL fatal_capture got %h/%b exp 40/111", last_fault_pc, last_fault_state); end
    checks++; if ({fault_cnt_A, fault_cnt_B, fault_cnt_C} !== {8'd1, 8'd0, 8'd0}) begin
      errors++; $display("FAIL fatal_cnts got %0d/%0d/%0d exp 1/0/0", fault_cnt_A, fault_cnt_B, fault_cnt_C); end
    Voter_state = 3'b000; step(1);
    pulse(3'b001, 32'h44);
    checks++; if (fault_cnt_A !== 8'd2 || fatal !== 1'b1 || last_fault_state !== 3'b001) begin
      errors++; $display("FAIL fatal_absorb got a=%0d fatal=%b st=%b exp 2/1/001", fault_cnt_A, fatal, last_fault_state); end
  endtask

  task automatic test_two_degraded_clr();
    do_clr();
    for (int i = 0; i < 4; i++) pulse(3'b001, 32'h500);
    for (int i = 0; i < 4; i++) pulse(3'b010, 32'h600);
    step(2);
    checks++; if (core_degraded !== 3'b011 || fatal !== 1'b1) begin
      errors++; $display("FAIL two_degraded got deg=%b fatal=%b exp 011/1", core_degraded, fatal); end
    clr = 1'b1; Voter_state = 3'b100; PC_Top = 32'h700;
    step(1);
    clr = 1'b0; Voter_state = 3'b000;
    checks++; if ({fault_cnt_A, fault_cnt_B, fault_cnt_C} !== 24'd0 || core_degraded !== 3'b000) begin
      errors++; $display("FAIL clr_cnts got %h deg=%b exp 0/000", {fault_cnt_A, fault_cnt_B, fault_cnt_C}, core_degraded); end
    checks++; if (fault_irq !== 1'b0 || last_fault_state !== 3'b000 || last_fault_pc !== 32'h0) begin
      errors++; $display("FAIL clr_drops_evt got irq=%b %b/%h exp 0 000/0", fault_irq, last_fault_state, last_fault_pc); end
    checks++; if (dbg_state !== S_OK || fatal !== 1'b0) begin
      errors++; $display("FAIL clr_state got %0d fatal=%b exp %0d/0", dbg_state, fatal, S_OK); end
    step(1);
  endtask

  task automatic test_wrap_inc();
    do_clr();
    for (int i = 0; i < 3; i++) pulse(3'b001, 32'h800);
    pulse(3'b100, 32'h900);
    step(247);
    checks++; if (fault_cnt_A !== 8'd3 || fault_cnt_C !== 8'd1) begin
      errors++; $display("FAIL pre_wrap got a=%0d c=%0d exp 3/1", fault_cnt_A, fault_cnt_C); end
    Voter_state = 3'b001;
    step(1);
    checks++; if (fault_cnt_A !== 8'd4 || fault_cnt_C !== 8'd0) begin
      errors++; $display("FAIL wrap_inc_wins got a=%0d c=%0d exp 4/0", fault_cnt_A, fault_cnt_C); end
    Voter_state = 3'b000;
    step(1);
  endtask

  task automatic test_saturation();
    do_clr();
    for (int i = 0; i < 3; i++) pulse(3'b001, 32'hA00);
    checks++; if (s_cnt_A !== 2'd3) begin
      errors++; $display("FAIL sat_reach got %0d exp 3", s_cnt_A); end
    pulse(3'b001, 32'hA04);
    checks++; if (s_cnt_A !== 2'd3 || fault_cnt_A !== 8'd4) begin
      errors++; $display("FAIL sat_hold got s=%0d main=%0d exp 3/4", s_cnt_A, fault_cnt_A); end
  endtask

  initial begin
    test_reset();
    test_persistent();
    test_degrade_decay();
    test_fatal();
    test_two_degraded_clr();
    test_wrap_inc();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmr_fault_monitor.md
Name: tmr_fault_monitor

Overview:
- Sits directly downstream of the TMR voter, alongside the lockstep controller.
- Consumes the voter's per-cycle disagreement code and the voted PC.
- Keeps a leaky per-core fault count, flags cores that misbehave persistently, and escalates to a sticky fatal state on uncorrectable disagreement.
- Provides fault capture registers and an interrupt pulse for software or debug.

Parameters:
CNT_W, 8, width of each per-core fault counter (saturating)
DEGRADE_THRESH, 4, count at or above which a core is marked degraded
WINDOW, 256, decay period in cycles; each elapsed period every nonzero counter leaks by 1

Ports:
clk  input  1  system clock, rising edge
rst_in  input  1  synchronous active-low reset
Voter_state  input  3  voter disagreement code; bit0=core A outvoted, bit1=B, bit2=C
PC_Top  input  32  voted PC for the current cycle
core_hold  input  1  cores held by the lockstep controller; sampling suppressed while 1
clr  input  1  synchronous software clear of all monitor state
fault_cnt_A  output  CNT_W  core A fault count
fault_cnt_B  output  CNT_W  core B fault count
fault_cnt_C  output  CNT_W  core C fault count
core_degraded  output  3  sticky per-core degraded flags, same bit order as Voter_state
fatal  output  1  sticky uncorrectable-fault flag
last_fault_pc  output  32  PC_Top captured at the most recent fault event
last_fault_state  output  3  Voter_state captured at the most recent fault event
fault_irq  output  1  one-cycle pulse per fault event

Behaviour:
- Clock and reset: single clock. Reset is synchronous, active-low, on rst_in. While rst_in=0 at a rising edge, every output and internal register goes to 0 and the FSM goes to S_OK.
- All outputs are registered. An event sampled at edge N is visible after edge N; it appears on fault_irq, the counters and the capture registers in cycle N+1.
- Sampling and event qualification:
  - A cycle is sampled only when core_hold=0.
  - A held cycle leaves the previous-state register unchanged.
  - An event is a sampled cycle where Voter_state is nonzero and differs from the previous sampled Voter_state. A persistent mismatch therefore counts once.
  - A return to 000 re-arms detection.
- Event classes:
  - Single-bit Voter_state (001/010/100) is correctable. It increments that core's counter, saturating at 2^CNT_W-1.
  - Any code with popcount>=2 (011, 101, 110, 111) is uncorrectable. No counter changes and the FSM goes to S_FATAL.
- On every event: fault_irq=1 for one cycle, and last_fault_pc and last_fault_state are loaded. Capture is overwrite-on-event with no holding.
- Decay:
  - A free-running window counter counts 0..WINDOW-1 and wraps. It runs during core_hold.
  - On the wrap cycle, each counter >0 decrements by 1.
  - If the same core takes a correctable event on the wrap cycle, the increment wins and the decrement is skipped for that core.
- Degraded flags:
  - core_degraded[i] sets when its count is >= DEGRADE_THRESH.
  - The flag is sticky: decay below the threshold does not clear it.
- FSM (2-bit):
  - S_OK: no flags set.
  - S_OK -> S_DEGRADED when exactly one core_degraded bit is set.
  - S_OK or S_DEGRADED -> S_FATAL on an uncorrectable event, or when two or more core_degraded bits are set.
  - S_FATAL is absorbing; it exits only via clr or reset.
  - fatal = (state == S_FATAL).
- clr: acts like reset, except the window counter also restarts at 0. If clr and an event occur in the same cycle, clr wins and the event is dropped: no irq, no capture.
- Reset mid-event: reset dominates everything, including a pending irq.

Decomposition:
- Shared package tmr_pkg holds:
  - FSM state encodings S_OK=0, S_DEGRADED=1, S_FATAL=2.
  - Voter_state bit indices VS_A=0, VS_B=1, VS_C=2.
  - VS_AGREE=3'b000.
- One sub-module, fault_leaky_counter, instantiated three times. It has inputs inc, dec and clr and a CNT_W-bit saturating output. Increment has priority over decrement, and the counter does not decrement below 0.
- The window counter, event detection, capture registers and FSM stay in the top block.

Test Plan:
- Reset with rst_in=0 for 2 cycles while driving Voter_state=001 -> all outputs 0, no irq. After release, first 001 -> fault_cnt_A=1, irq pulse, last_fault_state=001.
- Hold Voter_state=010 for 10 cycles -> fault_cnt_B=1 (single event). Then 000, 010 -> fault_cnt_B=2. With core_hold=1, toggling 000/010 -> no change.
- Four separated 100 events, DEGRADE_THRESH=4 -> core_degraded=100, state S_DEGRADED. Then let 2*WINDOW idle cycles pass -> fault_cnt_C=2, core_degraded still 100.
- Single 111 event at PC_Top=0x0000_0040 -> fatal=1, last_fault_pc=0x40, all counters unchanged. Further 001 events still count, and fatal stays 1.
- Degrade A then B -> fatal=1. Then assert clr together with a 100 event -> all zero, no irq, state S_OK.
- Correctable event on core A on the window wrap cycle with fault_cnt_A=3 -> fault_cnt_A=4, not 3. Saturation check with CNT_W=2: fourth event holds at 3.
